alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_pkg.sv | 53 +++++
 rtl/alu_issue_decode.sv | 54 +++++
 rtl/alu_issue_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ALU option codes,
// MIPS opcode/funct encodings, FSM state type and operand selectors.
package alu_issue_ctrl_pkg;

  // 4-bit ALU option encodings
  localparam logic [3:0] OPT_AND  = 4'b0000;
  localparam logic [3:0] OPT_OR   = 4'b0001;
  localparam logic [3:0] OPT_ADD  = 4'b0010;
  localparam logic [3:0] OPT_XOR  = 4'b0011;
  localparam logic [3:0] OPT_SLL  = 4'b0100;
  localparam logic [3:0] OPT_SRL  = 4'b0101;
  localparam logic [3:0] OPT_SUB  = 4'b0110;
  localparam logic [3:0] OPT_SLT  = 4'b0111;
  localparam logic [3:0] OPT_MUL  = 4'b1000;
  localparam logic [3:0] OPT_DIV  = 4'b1001;
  localparam logic [3:0] OPT_SRA  = 4'b1010;
  localparam logic [3:0] OPT_NOR  = 4'b1100;
  localparam logic [3:0] OPT_MOVE = 4'b1111;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  // R-type funct codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic [1:0] {IDLE, EXEC, DWAIT, RESP} state_t;

  typedef enum logic [1:0] {SEL1_RS, SEL1_RT, SEL1_IMM} op1_sel_t;

  typedef enum logic [2:0] {SEL2_RT, SEL2_SHAMT, SEL2_SIMM, SEL2_ZIMM, SEL2_SIXTEEN} op2_sel_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction decode: opcode/funct -> ALU option, operand
// selects, illegal flag and DIV marker. MULT/DIV decoding is present only
// when ALU_ISSUE_MULDIV_EN is defined; otherwise they decode as illegal.
module alu_issue_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] option,
  output op1_sel_t   op1_sel,
  output op2_sel_t   op2_sel,
  output logic       illegal,
  output logic       is_div
);

  // Decode table; unknown encodings fall through to MOVE with rs/rt operands
  always_comb begin
    option  = OPT_MOVE;
    op1_sel = SEL1_RS;
    op2_sel = SEL2_RT;
    illegal = 1'b0;
    is_div  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: option = OPT_ADD;
          F_SUB, F_SUBU: option = OPT_SUB;
          F_AND:         option = OPT_AND;
          F_OR:          option = OPT_OR;
          F_XOR:         option = OPT_XOR;
          F_NOR:         option = OPT_NOR;
          F_SLT:         option = OPT_SLT;
          F_SLL: begin option = OPT_SLL; op1_sel = SEL1_RT; op2_sel = SEL2_SHAMT; end
          F_SRL: begin option = OPT_SRL; op1_sel = SEL1_RT; op2_sel = SEL2_SHAMT; end
          F_SRA: begin option = OPT_SRA; op1_sel = SEL1_RT; op2_sel = SEL2_SHAMT; end
`ifdef ALU_ISSUE_MULDIV_EN
          F_MULT:        option = OPT_MUL;
          F_DIV: begin option = OPT_DIV; is_div = 1'b1; end
`endif
          default:       illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin option = OPT_ADD; op2_sel = SEL2_SIMM; end
      OP_SLTI:           begin option = OPT_SLT; op2_sel = SEL2_SIMM; end
      OP_ANDI:           begin option = OPT_AND; op2_sel = SEL2_ZIMM; end
      OP_ORI:            begin option = OPT_OR;  op2_sel = SEL2_ZIMM; end
      OP_XORI:           begin option = OPT_XOR; op2_sel = SEL2_ZIMM; end
      OP_BEQ:            option = OPT_SUB;
      OP_LUI: begin option = OPT_SLL; op1_sel = SEL1_IMM; op2_sel = SEL2_SIXTEEN; end
      default:           illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one MIPS instruction at a time, drives an
// external combinational ALU from latched operands, captures the result and
// presents it on a valid/ready response port. Multi-cycle DIV support is
// enabled by ALU_ISSUE_MULDIV_EN (decoded in alu_issue_decode).
module alu_issue_ctrl #(
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] alu_oprd1,
  output logic [31:0] alu_oprd2,
  output logic [3:0]  alu_option,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_illegal
);
  import alu_issue_ctrl_pkg::*;

  localparam logic [3:0] DIV_LAST = 4'(DIV_CYCLES - 1);

  state_t      state, next_state;
  logic [5:0]  opcode_q;
  logic [15:0] imm_q;
  logic [31:0] rs_q, rt_q;
  logic [3:0]  cnt_q;

  logic [3:0]  dec_option;
  op1_sel_t    op1_sel;
  op2_sel_t    op2_sel;
  logic        dec_illegal, dec_is_div;
  logic [31:0] oprd1, oprd2;
  logic        div_zero;
  logic        load, cap_alu, cap_div0, cnt_start, cnt_inc, set_valid, clr_valid;

  alu_issue_decode u_decode (
    .opcode  (opcode_q),
    .funct   (imm_q[5:0]),
    .option  (dec_option),
    .op1_sel (op1_sel),
    .op2_sel (op2_sel),
    .illegal (dec_illegal),
    .is_div  (dec_is_div)
  );

  assign in_ready = (state == IDLE);
  assign div_zero = dec_is_div && (rt_q == '0);

  // Operand selection from latched instruction fields and registers
  always_comb begin
    oprd1 = rs_q;
    oprd2 = rt_q;
    case (op1_sel)
      SEL1_RT:  oprd1 = rt_q;
      SEL1_IMM: oprd1 = {16'b0, imm_q};
      default:  oprd1 = rs_q;
    endcase
    case (op2_sel)
      SEL2_SHAMT:   oprd2 = {27'b0, imm_q[10:6]};
      SEL2_SIMM:    oprd2 = {{16{imm_q[15]}}, imm_q};
      SEL2_ZIMM:    oprd2 = {16'b0, imm_q};
      SEL2_SIXTEEN: oprd2 = 32'd16;
      default:      oprd2 = rt_q;
    endcase
  end

  // ALU drive: parked at zero/MOVE while idle
  always_comb begin
    alu_option = OPT_MOVE;
    alu_oprd1  = '0;
    alu_oprd2  = '0;
    if (state != IDLE) begin
      alu_option = dec_option;
      alu_oprd1  = oprd1;
      alu_oprd2  = oprd2;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and datapath control
  always_comb begin
    next_state = state;
    load       = 1'b0;
    cap_alu    = 1'b0;
    cap_div0   = 1'b0;
    cnt_start  = 1'b0;
    cnt_inc    = 1'b0;
    set_valid  = 1'b0;
    clr_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (div_zero) begin
          cap_div0   = 1'b1;
          next_state = RESP;
        end else if (dec_is_div && (DIV_CYCLES > 1)) begin
          cnt_start  = 1'b1;
          next_state = DWAIT;
        end else begin
          cap_alu    = 1'b1;
          next_state = RESP;
        end
      end
      DWAIT: begin
        // cnt_q counts operand-hold cycles already completed, EXEC included
        if (cnt_q == DIV_LAST) begin
          cap_alu    = 1'b1;
          next_state = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        // out_valid rises one cycle after entering RESP, so a response is
        // presented two edges after acceptance for single-cycle operations
        if (!out_valid) begin
          set_valid = 1'b1;
        end else if (out_ready) begin
          clr_valid  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Latched operands, DIV counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q    <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      cnt_q       <= '0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      if (load) begin
        opcode_q <= instr[31:26];
        imm_q    <= instr[15:0];
        rs_q     <= rs_val;
        rt_q     <= rt_val;
      end
      if (cap_alu) begin
        out_result  <= alu_result;
        out_zero    <= alu_zero;
        out_illegal <= dec_illegal;
      end else if (cap_div0) begin
        out_result  <= '0;
        out_zero    <= 1'b1;
        out_illegal <= 1'b1;
      end
      if (cnt_start)    cnt_q <= 4'd1;
      else if (cnt_inc) cnt_q <= cnt_q + 4'd1;
      else if (cap_alu) cnt_q <= '0;
      if (set_valid)      out_valid <= 1'b1;
      else if (clr_valid) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl with a behavioural ALU and a result
// scoreboard. MULT/DIV cases are compiled in when ALU_ISSUE_MULDIV_EN is set.
module tb_alu_issue_ctrl;

  localparam int unsigned DC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr, rs_val, rt_val;
  logic [31:0] alu_oprd1, alu_oprd2;
  logic [3:0]  alu_option;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illegal;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  alu_issue_ctrl #(.DIV_CYCLES(DC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .alu_oprd1   (alu_oprd1),
    .alu_oprd2   (alu_oprd2),
    .alu_option  (alu_option),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    case (alu_option)
      4'b0000: alu_result = alu_oprd1 & alu_oprd2;
      4'b0001: alu_result = alu_oprd1 | alu_oprd2;
      4'b0010: alu_result = alu_oprd1 + alu_oprd2;
      4'b0011: alu_result = alu_oprd1 ^ alu_oprd2;
      4'b0100: alu_result = alu_oprd1 << alu_oprd2[4:0];
      4'b0101: alu_result = alu_oprd1 >> alu_oprd2[4:0];
      4'b0110: alu_result = alu_oprd1 - alu_oprd2;
      4'b0111: alu_result = ($signed(alu_oprd1) < $signed(alu_oprd2)) ? 32'd1 : 32'd0;
      4'b1000: alu_result = alu_oprd1 * alu_oprd2;
      4'b1001: alu_result = (alu_oprd2 == 0) ? 32'd0 : alu_oprd1 / alu_oprd2;
      4'b1010: alu_result = $signed(alu_oprd1) >>> alu_oprd2[4:0];
      4'b1100: alu_result = ~(alu_oprd1 | alu_oprd2);
      default: alu_result = alu_oprd1;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, operand checks, latency, result, optional stall
  task automatic run_txn(input string tag, input logic [31:0] i, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [3:0] eopt,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input logic [31:0] eres, input logic ezero, input logic eill,
                         input int unsigned elat, input int unsigned stall);
    exp_t e;
    exp_t got;
    int unsigned cyc;
    @(negedge clk);
    instr = i; rs_val = rs; rt_val = rt; in_valid = 1'b1;
    out_ready = (stall == 0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    e.res = eres; e.zero = ezero; e.ill = eill;
    sb.push_back(e);
    // garbage on the input port while busy must not reach the ALU
    instr = $urandom; rs_val = $urandom; rt_val = $urandom;
    chk({tag, " option"}, 32'(alu_option), 32'(eopt));
    chk({tag, " oprd1"}, alu_oprd1, e1);
    chk({tag, " oprd2"}, alu_oprd2, e2);
    chk({tag, " busy in_ready"}, 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      chk({tag, " hold option"}, 32'(alu_option), 32'(eopt));
      chk({tag, " hold oprd1"}, alu_oprd1, e1);
      chk({tag, " hold oprd2"}, alu_oprd2, e2);
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, 32'(cyc), 32'(elat));
    got = sb.pop_front();
    if (out_valid) begin
      chk({tag, " result"}, out_result, got.res);
      chk({tag, " zero"}, 32'(out_zero), 32'(got.zero));
      chk({tag, " illegal"}, 32'(out_illegal), 32'(got.ill));
    end
    for (int s = 0; s < int'(stall); s++) begin
      @(posedge clk); #1;
      chk({tag, " stall valid"}, 32'(out_valid), 32'd1);
      chk({tag, " stall result"}, out_result, got.res);
      chk({tag, " stall zero"}, 32'(out_zero), 32'(got.zero));
      chk({tag, " stall illegal"}, 32'(out_illegal), 32'(got.ill));
      chk({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " done valid"}, 32'(out_valid), 32'd0);
    chk({tag, " done in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Start a transaction, hold it, reset n cycles after acceptance
  task automatic reset_mid(input string tag, input logic [31:0] i, input logic [31:0] rs,
                           input logic [31:0] rt, input int unsigned n);
    logic seen;
    @(negedge clk);
    instr = i; rs_val = rs; rt_val = rt; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, " rst in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " rst out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " rst result"}, out_result, 32'd0);
    chk({tag, " rst zero"}, 32'(out_zero), 32'd0);
    chk({tag, " rst illegal"}, 32'(out_illegal), 32'd0);
    chk({tag, " rst option"}, 32'(alu_option), 32'hF);
    chk({tag, " rst oprd1"}, alu_oprd1, 32'd0);
    chk({tag, " rst oprd2"}, alu_oprd2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk({tag, " no valid after rst"}, 32'(seen), 32'd0);
    chk({tag, " in_ready after rst"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; rs_val = '0; rt_val = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", out_result, 32'd0);
    chk("reset zero", 32'(out_zero), 32'd0);
    chk("reset illegal", 32'(out_illegal), 32'd0);
    chk("reset option", 32'(alu_option), 32'hF);
    chk("reset oprd1", alu_oprd1, 32'd0);
    chk("reset oprd2", alu_oprd2, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //      tag    instr         rs            rt           opt     oprd1         oprd2         result        z     ill   lat stall
    run_txn("add",  32'h012A4020, 32'd5,        32'd7,       4'b0010, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 2, 0);
    run_txn("beq",  32'h10220010, 32'h1234,     32'h1234,    4'b0110, 32'h1234,     32'h1234,     32'd0,        1'b1, 1'b0, 2, 0);
    run_txn("addi", 32'h2000FFFF, 32'd1,        32'd9,       4'b0010, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 2, 0);
    run_txn("andi", 32'h3000FFFF, 32'h12345678, 32'd9,       4'b0000, 32'h12345678, 32'h0000FFFF, 32'h00005678, 1'b0, 1'b0, 2, 0);
    run_txn("sll",  32'h00000100, 32'hDEAD,     32'h0F,      4'b0100, 32'h0F,       32'd4,        32'hF0,       1'b0, 1'b0, 2, 0);
    run_txn("sra",  32'h00000203, 32'hBEEF,     32'h80000000,4'b1010, 32'h80000000, 32'd8,        32'hFF800000, 1'b0, 1'b0, 2, 0);
    run_txn("lui",  32'h3C00ABCD, 32'h1111,     32'h2222,    4'b0100, 32'h0000ABCD, 32'd16,       32'hABCD0000, 1'b0, 1'b0, 2, 0);
    run_txn("slt",  32'h0000002A, 32'hFFFFFFFD, 32'd2,       4'b0111, 32'hFFFFFFFD, 32'd2,        32'd1,        1'b0, 1'b0, 2, 0);
    run_txn("nor",  32'h00000027, 32'hF0F0F0F0, 32'h0F0F0000,4'b1100, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 1'b0, 1'b0, 2, 0);
    run_txn("ill",  32'hFC000000, 32'h55,       32'h66,      4'b1111, 32'h55,       32'h66,       32'h55,       1'b0, 1'b1, 2, 0);
`ifdef ALU_ISSUE_MULDIV_EN
    run_txn("mult", 32'h00000018, 32'd6,        32'd7,       4'b1000, 32'd6,        32'd7,        32'd42,       1'b0, 1'b0, 2, 0);
    run_txn("div",  32'h0000001A, 32'd100,      32'd7,       4'b1001, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, DC + 1, 0);
    run_txn("div0", 32'h0000001A, 32'd100,      32'd0,       4'b1001, 32'd100,      32'd0,        32'd0,        1'b1, 1'b1, 2, 0);
    reset_mid("rst dwait", 32'h0000001A, 32'd100, 32'd7, 1);
`else
    run_txn("div",  32'h0000001A, 32'd100,      32'd7,       4'b1111, 32'd100,      32'd7,        32'd100,      1'b0, 1'b1, 2, 0);
    run_txn("mult", 32'h00000018, 32'd6,        32'd7,       4'b1111, 32'd6,        32'd7,        32'd6,        1'b0, 1'b1, 2, 0);
`endif
    run_txn("xor stall", 32'h00000026, 32'hFF00FF00, 32'h0FF00FF0, 4'b0011, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 1'b0, 2, 5);
    reset_mid("rst exec", 32'h012A4020, 32'd5, 32'd7, 0);
    reset_mid("rst resp", 32'h012A4020, 32'd5, 32'd7, 3);
    run_txn("add again", 32'h012A4020, 32'd40, 32'd2, 4'b0010, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
